rv32i_fetch_queue: RTL and testbench

RV32I_FETCH_QUEUE -- requirements
Module: rv32i_fetch_queue

---
 rtl/rv32i_fetch_queue.sv | 192 +++++++++++++++++++
 tb/tb_rv32i_fetch_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_queue.sv
// rv32i_fetch_queue: instruction fetch front end for an RV32I core.
// Issues word-aligned fetch requests with credit-based flow control.
// Tags each request with its PC and buffers responses in a small queue
// that feeds decode. On a redirect it flushes the queue and drains the
// stale in-flight responses before it resumes fetching at the new target.
module rv32i_fetch_queue #(
  parameter logic [31:0] PC_RESET        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  outstanding_q, outstanding_d;
  logic [4:0]  drop_cnt_q, drop_cnt_d;

  // Instruction queue: instruction word plus the PC it was fetched from.
  logic [31:0]   iq_instr_mem [FIFO_DEPTH];
  logic [31:0]   iq_pc_mem    [FIFO_DEPTH];
  logic [PW-1:0] iq_wr_ptr_q, iq_wr_ptr_d;
  logic [PW-1:0] iq_rd_ptr_q, iq_rd_ptr_d;
  logic [CW-1:0] iq_count_q, iq_count_d;

  // In-flight tag queue. Memory answers in order, so the oldest tag
  // always belongs to the next response, stale or not. Depth covers
  // MAX_OUTSTANDING because that never exceeds FIFO_DEPTH.
  logic [31:0]   tag_mem [FIFO_DEPTH];
  logic [PW-1:0] tag_wr_ptr_q;
  logic [PW-1:0] tag_rd_ptr_q;

  logic       req_fire;
  logic       iq_push;
  logic       head_pop;
  logic [5:0] credit_used;

  // Queue slots already promised: buffered entries plus requests in flight.
  assign credit_used   = 6'(outstanding_q) + 6'(iq_count_q);
  assign imem_req_addr = pc_q;

  // Head outputs read straight from the queue; forced to zero when empty.
  assign if_valid = (iq_count_q != '0);
  assign if_instr = if_valid ? iq_instr_mem[iq_rd_ptr_q] : 32'd0;
  assign if_pc    = if_valid ? iq_pc_mem[iq_rd_ptr_q]    : 32'd0;

  // Fetch FSM next state: request gating, PC, outstanding and drop counts.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    outstanding_d  = outstanding_q;
    drop_cnt_d     = drop_cnt_q;
    imem_req_valid = 1'b0;
    req_fire       = 1'b0;
    iq_push        = 1'b0;
    head_pop       = 1'b0;

    // Every request must have a guaranteed queue slot for its response.
    if (!reset && (state_q == FETCH) && !redirect_valid &&
        (outstanding_q < 5'(MAX_OUTSTANDING)) &&
        (credit_used < 6'(FIFO_DEPTH))) begin
      imem_req_valid = 1'b1;
    end
    req_fire = imem_req_valid && imem_req_ready;

    if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end

    case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + 5'd1;
      2'b01:   outstanding_d = outstanding_q - 5'd1;
      default: outstanding_d = outstanding_q;
    endcase

    // A redirect discards the head, so decode cannot consume it.
    head_pop = if_valid && if_ready && !redirect_valid;

    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          // Anything still in flight after this cycle is now stale.
          pc_d       = redirect_pc & 32'hFFFF_FFFC;
          drop_cnt_d = outstanding_d;
          if (outstanding_d != 5'd0) begin
            state_d = DRAIN;
          end
        end else begin
          iq_push = imem_rsp_valid;
        end
      end
      DRAIN: begin
        // Later redirects only retarget; the stale count does not change.
        if (redirect_valid) begin
          pc_d = redirect_pc & 32'hFFFF_FFFC;
        end
        if (imem_rsp_valid) begin
          drop_cnt_d = drop_cnt_q - 5'd1;
          if (drop_cnt_q == 5'd1) begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Instruction queue pointer and count next state, with flush on redirect.
  always_comb begin
    iq_wr_ptr_d = iq_wr_ptr_q;
    iq_rd_ptr_d = iq_rd_ptr_q;
    iq_count_d  = iq_count_q;
    if (redirect_valid) begin
      iq_wr_ptr_d = '0;
      iq_rd_ptr_d = '0;
      iq_count_d  = '0;
    end else begin
      if (iq_push) begin
        iq_wr_ptr_d = iq_wr_ptr_q + PW'(1);
      end
      if (head_pop) begin
        iq_rd_ptr_d = iq_rd_ptr_q + PW'(1);
      end
      case ({iq_push, head_pop})
        2'b10:   iq_count_d = iq_count_q + CW'(1);
        2'b01:   iq_count_d = iq_count_q - CW'(1);
        default: iq_count_d = iq_count_q;
      endcase
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= PC_RESET;
      outstanding_q <= 5'd0;
      drop_cnt_q    <= 5'd0;
      iq_wr_ptr_q   <= '0;
      iq_rd_ptr_q   <= '0;
      iq_count_q    <= '0;
      tag_wr_ptr_q  <= '0;
      tag_rd_ptr_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      iq_wr_ptr_q   <= iq_wr_ptr_d;
      iq_rd_ptr_q   <= iq_rd_ptr_d;
      iq_count_q    <= iq_count_d;
      if (req_fire) begin
        tag_wr_ptr_q <= tag_wr_ptr_q + PW'(1);
      end
      if (imem_rsp_valid) begin
        tag_rd_ptr_q <= tag_rd_ptr_q + PW'(1);
      end
    end
  end

  // Storage arrays need no reset; pointers and count define their contents.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr_ptr_q] <= pc_q;
    end
    if (iq_push) begin
      iq_instr_mem[iq_wr_ptr_q] <= imem_rsp_data;
      iq_pc_mem[iq_wr_ptr_q]    <= tag_mem[tag_rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Testbench for rv32i_fetch_queue. An in-order memory model with
// programmable latency answers requests. A scoreboard of expected
// {pc, instr} pairs is filled on each accepted request and checked on
// each head transfer.
module tb_rv32i_fetch_queue;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  rv32i_fetch_queue #(
    .PC_RESET(PC_RESET),
    .FIFO_DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        rdy_cfg = 1'b1;
  logic        ifr_cfg = 1'b1;
  logic        redir_req = 1'b0;
  logic [31:0] redir_target = 32'd0;
  logic [31:0] exp_pc = PC_RESET;
  int          stale_left = 0;
  bit          expect_resume = 1'b0;
  int          first_acc_cyc = -1;
  int          first_ifv_cyc = -1;
  int          acc_count = 0;
  int          pop_count = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive at the negedge, sample 1 time unit later, update model.
  task automatic run_cycle();
    bit    acc;
    bit    pop;
    bit    rsp;
    pend_t p;
    exp_t  e;
    imem_req_ready = rdy_cfg;
    if_ready       = ifr_cfg;
    redirect_valid = redir_req;
    redirect_pc    = redir_target;
    rsp = (pend_q.size() > 0) && (pend_q[0].rdy <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? instr_of(pend_q[0].addr) : $urandom();
    #1;
    acc = imem_req_valid && imem_req_ready;
    pop = if_valid && if_ready && !redirect_valid;

    if (redirect_valid) check("req_idle_on_redirect", 32'(imem_req_valid), 32'd0);
    if (stale_left > 0) check("no_req_in_drain", 32'(imem_req_valid), 32'd0);
    if (expect_resume && !redirect_valid) check("req_resume", 32'(imem_req_valid), 32'd1);
    expect_resume = 1'b0;
    if (if_valid && first_ifv_cyc < 0) first_ifv_cyc = cyc;

    if (pop) begin
      if (exp_q.size() == 0) begin
        check("head_unexpected", if_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("head_pc", if_pc, e.pc);
        check("head_instr", if_instr, e.instr);
        pop_log.push_back(if_pc);
        pop_count++;
        $display("head cyc=%0d pc=0x%08h instr=0x%08h", cyc, if_pc, if_instr);
      end
    end

    if (acc) begin
      check("req_addr", imem_req_addr, exp_pc);
      p.addr = imem_req_addr;
      p.rdy  = cyc + lat;
      pend_q.push_back(p);
      e.pc    = exp_pc;
      e.instr = instr_of(exp_pc);
      exp_q.push_back(e);
      acc_log.push_back(imem_req_addr);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      acc_count++;
      $display("req  cyc=%0d addr=0x%08h", cyc, imem_req_addr);
      exp_pc = exp_pc + 32'd4;
    end

    if (rsp) begin
      void'(pend_q.pop_front());
      if (stale_left > 0) begin
        stale_left--;
        if (stale_left == 0) expect_resume = 1'b1;
      end
    end

    if (redirect_valid) begin
      $display("redirect cyc=%0d target=0x%08h", cyc, redirect_pc);
      exp_q.delete();
      exp_pc        = redirect_pc & 32'hFFFF_FFFC;
      stale_left    = pend_q.size();
      expect_resume = (stale_left == 0);
      acc_log.delete();
      pop_log.delete();
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between clock edges; the memory model is reset too.
  task automatic do_reset();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    redir_req      = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_req_addr", imem_req_addr, PC_RESET);
    pend_q.delete();
    exp_q.delete();
    acc_log.delete();
    pop_log.delete();
    exp_pc        = PC_RESET;
    stale_left    = 0;
    first_acc_cyc = -1;
    first_ifv_cyc = -1;
    acc_count     = 0;
    pop_count     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset         = 1'b0;
    expect_resume = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if_ready       = 1'b0;

    // Streaming fetch after reset with 1-cycle memory.
    do_reset();
    lat = 1; rdy_cfg = 1'b1; ifr_cfg = 1'b1;
    repeat (12) run_cycle();
    check("ifv_after_accept", 32'(first_ifv_cyc - first_acc_cyc), 32'd2);
    check("t1_pc0", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0);
    check("t1_pc1", (pop_log.size() > 1) ? pop_log[1] : 32'hDEAD_BEEF, 32'h4);
    check("t1_pc2", (pop_log.size() > 2) ? pop_log[2] : 32'hDEAD_BEEF, 32'h8);

    // Decode stalled: the credit rule stops fetch at FIFO_DEPTH requests.
    do_reset();
    ifr_cfg = 1'b0;
    repeat (15) run_cycle();
    check("stall_accepts", 32'(acc_count), 32'd4);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_if_valid", 32'(if_valid), 32'd1);
    check("stall_head_pc", if_pc, PC_RESET);
    ifr_cfg = 1'b1;
    repeat (10) run_cycle();
    check("stall_drained", 32'(pop_count >= 4), 32'd1);

    // Redirect with two requests outstanding and no same-cycle response.
    do_reset();
    lat = 4;
    for (int i = 0; i < 10 && pend_q.size() < 2; i++) run_cycle();
    check("t3_outstanding", 32'(pend_q.size()), 32'd2);
    redir_req = 1'b1; redir_target = 32'h0000_0103;
    run_cycle();
    redir_req = 1'b0;
    for (int i = 0; i < 20 && acc_log.size() == 0; i++) run_cycle();
    check("t3_resume_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h0000_0100);
    repeat (12) run_cycle();
    check("t3_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_0100);

    // Redirect in the same cycle as a response.
    do_reset();
    lat = 2;
    for (int i = 0; i < 20 && !(pend_q.size() == 2 && pend_q[0].rdy <= cyc); i++) run_cycle();
    redir_req = 1'b1; redir_target = 32'h0000_0200;
    run_cycle();
    redir_req = 1'b0;
    repeat (12) run_cycle();
    check("t4_resume_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h0000_0200);
    check("t4_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_0200);

    // A second redirect while draining retargets only.
    do_reset();
    lat = 5;
    repeat (2) run_cycle();
    redir_req = 1'b1; redir_target = 32'h0000_0400;
    run_cycle();
    redir_req = 1'b0;
    run_cycle();
    redir_req = 1'b1; redir_target = 32'h0000_0502;
    run_cycle();
    redir_req = 1'b0;
    for (int i = 0; i < 20 && acc_log.size() == 0; i++) run_cycle();
    check("t5_resume_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h0000_0500);
    repeat (14) run_cycle();
    check("t5_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_0500);

    // The fetch PC wraps from the top of the address space to zero.
    do_reset();
    lat = 1;
    redir_req = 1'b1; redir_target = 32'hFFFF_FFFC;
    run_cycle();
    redir_req = 1'b0;
    repeat (10) run_cycle();
    check("wrap_addr0", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_addr1", (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);
    check("wrap_pc1", (pop_log.size() > 1) ? pop_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Reset mid-operation with the credit window full.
    do_reset();
    lat = 6; ifr_cfg = 1'b0;
    repeat (9) run_cycle();
    check("t7_busy_if_valid", 32'(if_valid), 32'd1);
    check("t7_busy_req_valid", 32'(imem_req_valid), 32'd0);
    do_reset();
    lat = 1; ifr_cfg = 1'b1;
    repeat (6) run_cycle();
    check("t7_first_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, PC_RESET);
    check("t7_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, PC_RESET);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
